// File: rtl/dm_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter.
// The width constants mirror the core's data path and instruction memory size.
package dm_arbiter_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int WORDS_INSTRUCTION = 256;
  localparam int DM_ARB_LOCK_MAX   = 8;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester-side bus of the data-memory arbiter.
// Addresses and write data are packed; requester i occupies slice i.
interface dm_arbiter_if
  import dm_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int AW    = $clog2(WORDS_INSTRUCTION),
  parameter int DW    = DATA_WIDTH
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_we;
  logic [N_REQ-1:0]    req_lock;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic [DW-1:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dm_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid bit at or after ptr, searching
// cyclically upward. Produces a one-hot grant, its index and an any-valid flag.
module dm_arbiter_rr_pick
  import dm_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Cyclic priority search starting at ptr
  always_comb begin
    logic [IW-1:0] j_v;
    logic          hit_v;
    j_v   = '0;
    hit_v = 1'b0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j_v        = IW'((int'(ptr) + k) % N);
      hit_v      = valid[j_v] & ~any;
      grant[j_v] = hit_v;
      idx        = hit_v ? j_v : idx;
      any        = any | hit_v;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between N_REQ
// requesters, with bounded-time lock for atomic read-modify-write sequences.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int LOCK_MAX = DM_ARB_LOCK_MAX,
  parameter int AW       = $clog2(WORDS_INSTRUCTION),
  parameter int DW       = DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  dm_arbiter_if.slave   bus,
  output logic          dm_we,
  output logic [AW-1:0] dm_address,
  output logic [DW-1:0] dm_data_in,
  input  logic [DW-1:0] dm_data_out
);

  localparam int IW = idx_width(N_REQ);
  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_e       state_r, state_nxt_s;
  logic [IW-1:0]    rr_ptr_r, rr_ptr_nxt_s, owner_r, owner_nxt_s;
  logic [IW-1:0]    pick_ptr_s, pick_idx_s;
  logic [CW-1:0]    lock_cnt_r, lock_cnt_nxt_s;
  logic [N_REQ-1:0] owner_mask_s, pick_valid_s, pick_grant_s, rsp_valid_r;
  logic             pick_any_s, xfer_s, xfer_we_s, xfer_lock_s;
  logic [AW-1:0]    xfer_addr_s;
  logic [DW-1:0]    xfer_wdata_s, rsp_rdata_r;

  function automatic logic [IW-1:0] inc_ptr(input logic [IW-1:0] p);
    if (p == IW'(N_REQ - 1)) begin
      return '0;
    end else begin
      return p + IW'(1);
    end
  endfunction

  // While locked only the owner competes, so the picker sees a masked vector
  always_comb begin
    owner_mask_s          = '0;
    owner_mask_s[owner_r] = 1'b1;
    if (state_r == ARB_LOCKED) begin
      pick_valid_s = bus.req_valid & owner_mask_s;
      pick_ptr_s   = owner_r;
    end else begin
      pick_valid_s = bus.req_valid;
      pick_ptr_s   = rr_ptr_r;
    end
  end

  dm_arbiter_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .valid (pick_valid_s),
    .ptr   (pick_ptr_s),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  // Grant and memory strobe are gated by rst_n so nothing reaches dm in reset
  assign xfer_s        = pick_any_s & rst_n;
  assign bus.req_ready = rst_n ? pick_grant_s : '0;

  // Route the winning requester onto the dm port
  always_comb begin
    xfer_we_s    = bus.req_we[pick_idx_s];
    xfer_lock_s  = bus.req_lock[pick_idx_s];
    xfer_addr_s  = bus.req_addr[pick_idx_s*AW +: AW];
    xfer_wdata_s = bus.req_wdata[pick_idx_s*DW +: DW];
    if (xfer_s) begin
      dm_we      = xfer_we_s;
      dm_address = xfer_addr_s;
      dm_data_in = xfer_wdata_s;
    end else begin
      dm_we      = 1'b0;
      dm_address = '0;
      dm_data_in = '0;
    end
  end

  // Lock FSM next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (xfer_s && xfer_lock_s) begin
          state_nxt_s = ARB_LOCKED;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        if (xfer_s && !xfer_lock_s) begin
          state_nxt_s = ARB_IDLE;
        end else if (lock_cnt_r == CW'(LOCK_MAX - 1)) begin
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_LOCKED;
        end
      end
      default: state_nxt_s = ARB_IDLE;
    endcase
  end

  // Pointer, owner and hold-counter updates per state
  always_comb begin
    rr_ptr_nxt_s   = rr_ptr_r;
    owner_nxt_s    = owner_r;
    lock_cnt_nxt_s = '0;
    case (state_r)
      ARB_IDLE: begin
        if (xfer_s && xfer_lock_s) begin
          owner_nxt_s = pick_idx_s;
        end else if (xfer_s) begin
          rr_ptr_nxt_s = inc_ptr(pick_idx_s);
        end else begin
          rr_ptr_nxt_s = rr_ptr_r;
        end
      end
      ARB_LOCKED: begin
        if (state_nxt_s == ARB_IDLE) begin
          rr_ptr_nxt_s = inc_ptr(owner_r);
        end else if (lock_cnt_r != CW'(LOCK_MAX)) begin
          lock_cnt_nxt_s = lock_cnt_r + CW'(1);
        end else begin
          lock_cnt_nxt_s = lock_cnt_r;
        end
      end
      default: begin
        rr_ptr_nxt_s   = '0;
        owner_nxt_s    = '0;
        lock_cnt_nxt_s = '0;
      end
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ARB_IDLE;
      rr_ptr_r   <= '0;
      owner_r    <= '0;
      lock_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
      owner_r    <= owner_nxt_s;
      lock_cnt_r <= lock_cnt_nxt_s;
    end
  end

  // Registered response, read data captured at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= '0;
      rsp_rdata_r <= '0;
    end else if (xfer_s) begin
      rsp_valid_r <= pick_grant_s;
      rsp_rdata_r <= xfer_we_s ? '0 : dm_data_out;
    end else begin
      rsp_valid_r <= '0;
      rsp_rdata_r <= '0;
    end
  end

  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;

endmodule
